// File: rtl/sample_pair_sum.sv
// Two-tap moving sum: registered sum of the current and previous 4-bit samples.
// Widths are fixed, so the 5-bit result (max 30) cannot overflow.
module sample_pair_sum (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  output logic [4:0] a_out
);

  logic [3:0] a_prev;
  logic [4:0] sum;

  // Zero-extend both taps before adding so the carry lands in bit 4.
  assign sum = {1'b0, a} + {1'b0, a_prev};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_prev <= '0;
      a_out  <= '0;
    end else begin
      a_prev <= a;
      a_out  <= sum;
    end
  end

endmodule

// File: tb/tb_sample_pair_sum.sv
// Scoreboard bench for sample_pair_sum.
// Expected sums are queued on drive and popped one edge later.
module tb_sample_pair_sum;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [4:0] a_out;
  logic       clk_run;

  int total;
  int bad;

  logic [4:0] sb_q[$];
  logic [3:0] m_prev;
  logic [4:0] m_last;

  sample_pair_sum dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .a_out(a_out)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [4:0] got,
    input logic [4:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (%b) exp=%0d (%b)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] v);
    logic [4:0] e;
    @(negedge clk);
    a = v;
    sb_q.push_back({1'b0, v} + {1'b0, m_prev});
    m_prev = v;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got=%0d", tag, a_out);
    end else begin
      e = sb_q.pop_front();
      m_last = e;
      chk(tag, a_out, e);
    end
  endtask

  task automatic pulse_rst(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk(tag, a_out, 5'd0);
    rst = 1'b0;
    sb_q.delete();
    m_prev = 4'd0;
    m_last = 5'd0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    clk_run = 1'b0;
    rst     = 1'b0;
    a       = 4'd0;
    m_prev  = 4'd0;
    m_last  = 5'd0;

    // Async reset with the clock stopped.
    #3;
    rst = 1'b1;
    #1;
    chk("rst_noclk", a_out, 5'd0);
    #2;
    rst = 1'b0;
    clk_run = 1'b1;

    for (int i = 0; i < 3; i++) step("idle_zero", 4'd0);

    pulse_rst("rst_first");
    step("first_5", 4'd5);
    step("hold_5", 4'd5);

    pulse_rst("rst_ramp");
    for (int i = 1; i <= 15; i++) step("ramp", 4'(i));
    step("max_30", 4'd15);
    chk("max_bits", a_out, 5'b11110);

    step("down_15", 4'd15);
    pulse_rst("rst_down");
    step("down_a15", 4'd15);
    step("down_a0", 4'd0);
    step("eight_a", 4'd8);
    step("eight_b", 4'd8);

    step("mid_12a", 4'd12);
    step("mid_24", 4'd12);
    pulse_rst("rst_mid");
    step("post_rst_12", 4'd12);

    // Glitchy input between edges; only the settled value counts.
    step("prev_4", 4'd4);
    @(negedge clk);
    a = 4'd9;
    #1 a = 4'd15;
    #1 a = 4'd0;
    #1 a = 4'd3;
    chk("stable_between", a_out, m_last);
    sb_q.push_back({1'b0, 4'd3} + {1'b0, m_prev});
    m_prev = 4'd3;
    @(posedge clk);
    #1;
    m_last = sb_q.pop_front();
    chk("glitch_7", a_out, m_last);
    chk("glitch_abs", a_out, 5'd7);

    step("tail_0", 4'd0);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got=%0d exp=0", sb_q.size());
    end

    clk_run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
